// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte width, arbiter state encoding and index-width helper.
package uart_pkg;
   localparam int UART_BYTE_W = 8;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START, ST_DRAIN} state_t;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick of the first set req bit after rr_ptr (wrapping).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    rr_ptr,
   output logic [IW-1:0]    winner,
   output logic             valid
);
   logic [IW-1:0] idx;
   always_comb begin
      winner = '0;
      idx    = '0;
      valid  = |req;
      // scan from farthest to nearest so the nearest set bit overwrites the rest
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IW'((int'(rr_ptr) + k) % N_REQ);
         winner = req[idx] ? idx : winner;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte requesters,
// with grant hold so multi-byte packets are never interleaved.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]             req_hold,
   output logic [N_REQ-1:0]             ack,
   output logic [N_REQ-1:0]             grant,
   output logic                         tx_enable,
   output logic [UART_BYTE_W-1:0]       tx_data,
   input  logic                         tx_busy,
   output logic                         busy,
   output logic                         timeout_err
);
   localparam int IW = idx_w(N_REQ);
   localparam int CW = START_TIMEOUT > 1 ? $clog2(START_TIMEOUT) : 1;
   state_t                 state_q;
   logic [IW-1:0]          owner_q, rr_ptr_q, win;
   logic                   pick_valid, hold_q, tx_enable_q, timeout_q;
   logic [CW-1:0]          cnt_q;
   logic [N_REQ-1:0]       ack_q, grant_q;
   logic [UART_BYTE_W-1:0] tx_data_q;
   logic [UART_BYTE_W-1:0] bytes [N_REQ];
   for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
      assign bytes[i] = req_data[UART_BYTE_W*i +: UART_BYTE_W];
   end
   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (win),
      .valid  (pick_valid)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= IW'(N_REQ - 1);
         hold_q      <= 1'b0;
         cnt_q       <= '0;
         ack_q       <= '0;
         grant_q     <= '0;
         tx_data_q   <= '0;
         tx_enable_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         ack_q     <= '0;
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (!tx_busy && pick_valid) begin
               grant_q <= N_REQ'(1) << win;
               owner_q <= win;
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               tx_data_q <= bytes[owner_q];
               ack_q     <= N_REQ'(1) << owner_q;
               hold_q    <= req_hold[owner_q];
               cnt_q     <= '0;
               state_q   <= ST_START;
            end
            // first START cycle raises tx_enable; the timeout counts from then on
            ST_START: if (!tx_enable_q) begin
               tx_enable_q <= 1'b1;
            end else if (tx_busy) begin
               tx_enable_q <= 1'b0;
               state_q     <= ST_DRAIN;
            end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
               timeout_q   <= 1'b1;
               tx_enable_q <= 1'b0;
               grant_q     <= '0;
               rr_ptr_q    <= owner_q;
               state_q     <= ST_IDLE;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            ST_DRAIN: if (!tx_busy) begin
               if (hold_q && req[owner_q]) begin
                  state_q <= ST_LOAD;
               end else if (!hold_q || !req_hold[owner_q]) begin
                  grant_q  <= '0;
                  rr_ptr_q <= owner_q;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
   assign ack         = ack_q;
   assign grant       = grant_q;
   assign tx_enable   = tx_enable_q;
   assign tx_data     = tx_data_q;
   assign timeout_err = timeout_q;
   assign busy        = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;
   typedef struct packed {logic [3:0] id; logic [7:0] data;} exp_t;
   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, req_hold, ack, grant;
   logic [8*N-1:0] req_data;
   logic          tx_enable, tx_busy, busy, timeout_err;
   logic [7:0]    tx_data, last_data;
   logic          force_busy, model_on, mb;
   int            ph, c;
   int            n_chk = 0, n_pass = 0;
   exp_t          sb[$];
   exp_t          mon_e;
   uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .req_hold    (req_hold),
      .ack         (ack),
      .grant       (grant),
      .tx_enable   (tx_enable),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .busy        (busy),
      .timeout_err (timeout_err)
   );
   always #5 clk = ~clk;
   assign tx_busy = force_busy | mb;
   // uart_tx model: busy rises 2 cycles after enable and stays high 10 cycles
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph <= 0; c <= 0; mb <= 1'b0;
      end else begin
         case (ph)
            0: if (tx_enable && model_on) ph <= 1;
            1: begin mb <= 1'b1; c <= 1; ph <= 2; end
            default: if (c == 10) begin mb <= 1'b0; ph <= 0; end else c <= c + 1;
         endcase
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic push(input int id, input logic [7:0] d);
      sb.push_back({4'(id), d});
   endtask
   always @(negedge clk) begin
      if (!rst && ack != 0) begin
         if (sb.size() == 0) check("spurious_ack", 32'(ack), 0);
         else begin
            mon_e = sb.pop_front();
            check("ack_onehot", 32'(ack), 32'(4'b1 << mon_e.id));
            check("ack_grant", 32'(grant), 32'(4'b1 << mon_e.id));
            check("ack_data", 32'(tx_data), 32'(mon_e.data));
            last_data = tx_data;
         end
      end
      if (!rst && tx_enable) check("tx_data_stable", 32'(tx_data), 32'(last_data));
   end
   task automatic wait_acks(input int n);
      int seen = 0;
      int t = 0;
      while (seen < n && t < 400) begin
         @(negedge clk);
         t++;
         if (ack != 0) seen++;
      end
      check("ack_count", seen, n);
   endtask
   task automatic wait_idle();
      int t = 0;
      while ((busy || tx_busy) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("idle_reached", 32'(busy | tx_busy), 0);
   endtask
   task automatic do_reset();
      rst = 1'b1; req = '0; req_hold = '0; req_data = '0; force_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int t, k;
      model_on = 1'b1;
      last_data = '0;
      do_reset();
      check("rst_ack", 32'(ack), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_tx_enable", 32'(tx_enable), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      // single request, latency grant -> ack -> tx_enable
      push(0, 8'hA5);
      req_data[7:0] = 8'hA5; req = 4'b0001;
      @(negedge clk); check("t1_grant", 32'(grant), 32'h1);
      @(negedge clk); check("t1_ack", 32'(ack), 32'h1);
      req = '0;
      @(negedge clk); check("t1_tx_enable", 32'(tx_enable), 1);
      check("t1_tx_data", 32'(tx_data), 32'hA5);
      wait_idle();
      check("t1_grant_end", 32'(grant), 0);
      check("t1_busy_end", 32'(busy), 0);
      // contention after reset: order 0,1,2,3,0
      do_reset();
      req_data = 32'h44332211;
      push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
      req = 4'b1111;
      wait_acks(5);
      req = '0;
      wait_idle();
      // hold packet from requester 2 while requester 1 waits
      req_data[23:16] = 8'h01; req_hold = 4'b0100; req = 4'b0100;
      push(2, 8'h01);
      wait_acks(1);
      req_data[23:16] = 8'h2C; req_hold = '0; req_data[15:8] = 8'h77; req = 4'b0110;
      push(2, 8'h2C); push(1, 8'h77);
      wait_acks(1);
      req = 4'b0010;
      wait_acks(1);
      req = '0;
      wait_idle();
      // start timeout with tx_busy stuck low
      model_on = 1'b0;
      req_data[15:8] = 8'h5A; req = 4'b0010;
      push(1, 8'h5A);
      wait_acks(1);
      req = '0;
      t = 0;
      while (!tx_enable && t < 50) begin @(negedge clk); t++; end
      check("t4_tx_enable_rose", 32'(tx_enable), 1);
      k = 0;
      while (!timeout_err && k < 100) begin @(negedge clk); k++; end
      check("t4_timeout_latency", k, TO);
      check("t4_grant_cleared", 32'(grant), 0);
      check("t4_tx_enable_low", 32'(tx_enable), 0);
      @(negedge clk); check("t4_timeout_pulse", 32'(timeout_err), 0);
      model_on = 1'b1;
      req_data[23:16] = 8'h66; req = 4'b0100;
      push(2, 8'h66);
      wait_acks(1);
      req = '0;
      wait_idle();
      // line busy in IDLE blocks the grant
      force_busy = 1'b1;
      req_data[31:24] = 8'hC3; req = 4'b1000;
      push(3, 8'hC3);
      repeat (6) @(negedge clk);
      check("t5_no_grant", 32'(grant), 0);
      check("t5_idle", 32'(busy), 0);
      force_busy = 1'b0;
      wait_acks(1);
      req = '0;
      wait_idle();
      // reset during START
      req_data[7:0] = 8'h99; req = 4'b0001;
      push(0, 8'h99);
      wait_acks(1);
      req = '0;
      @(negedge clk); check("t6_pre_tx_enable", 32'(tx_enable), 1);
      rst = 1'b1;
      #1;
      check("t6_rst_tx_enable", 32'(tx_enable), 0);
      check("t6_rst_grant", 32'(grant), 0);
      check("t6_rst_ack", 32'(ack), 0);
      check("t6_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      req_data = 32'h44332211; req = 4'b1111;
      push(0, 8'h11);
      wait_acks(1);
      req = '0;
      wait_idle();
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
